clock_display_scan: RTL and testbench

CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

---
 rtl/clock_display_scan.sv | 125 ++++++++++++
 tb/tb_clock_display_scan.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH:MM:SS display driver with frame snapshotting,
// out-of-range dashes and edit-mode blinking of the selected field.
module clock_display_scan #(
  parameter int NUM_DIG = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_scan,
  input  logic               ena_blink,
  input  logic [1:0]         select_mode,
  input  logic [5:0]         hour,
  input  logic [5:0]         min,
  input  logic [5:0]         sec,
  output logic [6:0]         seg,
  output logic [NUM_DIG-1:0] an,
  output logic               dp
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIG - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  logic [2:0] idx;
  logic [2:0] idx_next;
  logic       frame_start;
  logic       blink_phase;
  logic [1:0] prev_mode;
  logic [5:0] snap_hour;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;

  logic [5:0]         hour_v;
  logic [5:0]         field_v;
  logic               field_bad;
  logic [1:0]         field_sel;
  logic [5:0]         digit;
  logic [6:0]         glyph;
  logic               blank;
  logic [6:0]         seg_d;
  logic [NUM_DIG-1:0] an_d;
  logic               dp_d;

  function automatic logic [6:0] seg_of(input logic [5:0] d);
    case (d)
      6'd0:    seg_of = 7'b1000000;
      6'd1:    seg_of = 7'b1111001;
      6'd2:    seg_of = 7'b0100100;
      6'd3:    seg_of = 7'b0110000;
      6'd4:    seg_of = 7'b0011001;
      6'd5:    seg_of = 7'b0010010;
      6'd6:    seg_of = 7'b0000010;
      6'd7:    seg_of = 7'b1111000;
      6'd8:    seg_of = 7'b0000000;
      6'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_OFF;
    endcase
  endfunction

  // Digit 0 is drawn live on the frame-start tick; everything later in the
  // frame comes from the snapshot taken on that same tick.
  always_comb begin
    idx_next    = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    frame_start = (idx_next == 3'd0);
    hour_v      = frame_start ? hour : snap_hour;
    field_v     = sec;
    field_bad   = 1'b0;
    field_sel   = 2'd3;
    case (idx_next)
      3'd0, 3'd1: begin
        field_v   = hour_v;
        field_bad = (hour_v > 6'd23);
        field_sel = 2'd1;
      end
      3'd2, 3'd3: begin
        field_v   = snap_min;
        field_bad = (snap_min > 6'd59);
        field_sel = 2'd2;
      end
      default: begin
        field_v   = snap_sec;
        field_bad = (snap_sec > 6'd59);
        field_sel = 2'd3;
      end
    endcase
    digit = idx_next[0] ? (field_v % 6'd10) : (field_v / 6'd10);
    glyph = field_bad ? SEG_DASH : seg_of(digit);
    blank = blink_phase && (field_sel == select_mode);
    seg_d = blank ? SEG_OFF : glyph;
    an_d  = blank ? '1 : ~(NUM_DIG'(1) << idx_next);
    dp_d  = blank || !((idx_next == 3'd1) || (idx_next == 3'd3));
  end

  // A mode change restarts the blink so the newly selected field starts visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= LAST_IDX;
      blink_phase <= 1'b0;
      prev_mode   <= 2'd0;
      snap_hour   <= '0;
      snap_min    <= '0;
      snap_sec    <= '0;
      seg         <= SEG_OFF;
      an          <= '1;
      dp          <= 1'b1;
    end else begin
      prev_mode <= select_mode;
      if (select_mode != prev_mode)
        blink_phase <= 1'b0;
      else if (ena_blink)
        blink_phase <= ~blink_phase;
      if (ena_scan) begin
        idx <= idx_next;
        seg <= seg_d;
        an  <= an_d;
        dp  <= dp_d;
        if (frame_start) begin
          snap_hour <= hour;
          snap_min  <= min;
          snap_sec  <= sec;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: a field-level display model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_clock_display_scan;

  logic       clk;
  logic       rst;
  logic       ena_scan;
  logic       ena_blink;
  logic [1:0] select_mode;
  logic [5:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;

  int checks = 0;
  int failures = 0;

  clock_display_scan #(.NUM_DIG(6)) dut (
    .clk(clk), .rst(rst), .ena_scan(ena_scan), .ena_blink(ena_blink),
    .select_mode(select_mode), .hour(hour), .min(min), .sec(sec),
    .seg(seg), .an(an), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  int         m_pos = 5;
  int         m_phase = 0;
  int         m_prev = 0;
  int         m_snap_h = 0;
  int         m_snap_m = 0;
  int         m_snap_s = 0;
  bit         model_ready = 1'b0;
  logic [6:0] exp_seg = 7'h7F;
  logic [5:0] exp_an = 6'h3F;
  logic       exp_dp = 1'b1;

  // Model: which digit is lit, what its field value is, and whether that field blinks.
  always @(posedge clk) begin
    int fld, v, lim, d;
    if (rst) begin
      m_pos = 5; m_phase = 0; m_prev = 0;
      m_snap_h = 0; m_snap_m = 0; m_snap_s = 0;
      exp_seg = 7'h7F; exp_an = 6'h3F; exp_dp = 1'b1;
      model_ready = 1'b1;
    end else begin
      if (ena_scan) begin
        m_pos = (m_pos + 1) % 6;
        if (m_pos == 0) begin
          m_snap_h = int'(hour); m_snap_m = int'(min); m_snap_s = int'(sec);
        end
        fld = m_pos / 2;
        if (fld == 0) begin
          v = (m_pos == 0) ? int'(hour) : m_snap_h;
          lim = 23;
        end else begin
          v = (fld == 1) ? m_snap_m : m_snap_s;
          lim = 59;
        end
        if (m_phase == 1 && int'(select_mode) == fld + 1) begin
          exp_seg = 7'h7F; exp_an = 6'h3F; exp_dp = 1'b1;
        end else begin
          d = (m_pos % 2 == 0) ? v / 10 : v % 10;
          exp_seg = (v > lim) ? 7'b0111111 : glyph_tab[d];
          exp_an = ~(6'(1) << m_pos);
          exp_dp = !(m_pos == 1 || m_pos == 3);
        end
      end
      if (int'(select_mode) != m_prev) m_phase = 0;
      else if (ena_blink) m_phase = 1 - m_phase;
      m_prev = int'(select_mode);
    end
  end

  // Every cycle after the first reset edge the DUT must match the model.
  always @(negedge clk) begin
    if (model_ready) begin
      checks++;
      if (seg !== exp_seg || an !== exp_an || dp !== exp_dp) begin
        failures++;
        $display("[TB] FAIL model_cycle t=%0t: got seg=%b an=%b dp=%b, want seg=%b an=%b dp=%b",
                 $time, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
  end

  task automatic applyStimulus(input logic scan, input logic blink);
    @(negedge clk);
    ena_scan = scan;
    ena_blink = blink;
    @(negedge clk);
    ena_scan = 1'b0;
    ena_blink = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] s,
                             input logic [5:0] a, input logic d);
    checks++;
    if (seg !== s || an !== a || dp !== d) begin
      failures++;
      $display("[TB] FAIL %s: got seg=%b an=%b dp=%b, want seg=%b an=%b dp=%b",
               name, seg, an, dp, s, a, d);
    end
  endtask

  task automatic scanN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ena_scan = 1'b0; ena_blink = 1'b0; select_mode = 2'd0;
    hour = 6'd12; min = 6'd34; sec = 6'd56;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 7'h7F, 6'h3F, 1'b1);
    rst = 1'b0;

    $display("[TB] basic frame 12:34:56");
    applyStimulus(1'b1, 1'b0); checkOutput("f1_d0", 7'b1111001, 6'b111110, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("f1_d1", 7'b0100100, 6'b111101, 1'b0);
    applyStimulus(1'b1, 1'b0); checkOutput("f1_d2", 7'b0110000, 6'b111011, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("f1_d3", 7'b0011001, 6'b110111, 1'b0);
    applyStimulus(1'b1, 1'b0); checkOutput("f1_d4", 7'b0010010, 6'b101111, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("f1_d5", 7'b0000010, 6'b011111, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("hold_between_ticks", 7'b0000010, 6'b011111, 1'b1);

    $display("[TB] snapshot: sec changes mid-frame");
    scanN(2);
    sec = 6'd57;
    scanN(4); checkOutput("tear_old_sec", 7'b0000010, 6'b011111, 1'b1);
    scanN(6); checkOutput("tear_new_sec", 7'b1111000, 6'b011111, 1'b1);

    $display("[TB] edit minute blinking");
    @(negedge clk); select_mode = 2'd2;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("blink_d0_visible", 7'b1111001, 6'b111110, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0); checkOutput("blink_d2_blank", 7'h7F, 6'h3F, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("blink_d3_blank", 7'h7F, 6'h3F, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("blink_d4_visible", 7'b0010010, 6'b101111, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    scanN(3); checkOutput("unblink_d2", 7'b0110000, 6'b111011, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("unblink_d3", 7'b0011001, 6'b110111, 1'b0);
    scanN(2);

    $display("[TB] mode change clears blink over simultaneous tick");
    @(negedge clk); select_mode = 2'd1;
    applyStimulus(1'b0, 1'b1);
    @(negedge clk); select_mode = 2'd3; ena_blink = 1'b1;
    @(negedge clk); ena_blink = 1'b0;
    applyStimulus(1'b1, 1'b0); checkOutput("clr_hour_visible", 7'b1111001, 6'b111110, 1'b1);
    scanN(3);
    applyStimulus(1'b1, 1'b1); checkOutput("simul_pre_toggle", 7'b0010010, 6'b101111, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("simul_post_toggle", 7'h7F, 6'h3F, 1'b1);

    $display("[TB] out-of-range and boundary values");
    @(negedge clk); select_mode = 2'd0; hour = 6'd30; min = 6'd7; sec = 6'd0;
    applyStimulus(1'b1, 1'b0); checkOutput("dash_d0", 7'b0111111, 6'b111110, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("dash_d1", 7'b0111111, 6'b111101, 1'b0);
    applyStimulus(1'b1, 1'b0); checkOutput("min07_d2", 7'b1000000, 6'b111011, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("min07_d3", 7'b1111000, 6'b110111, 1'b0);
    scanN(2);
    hour = 6'd23; min = 6'd60; sec = 6'd59;
    applyStimulus(1'b1, 1'b0); checkOutput("hour23_d0", 7'b0100100, 6'b111110, 1'b1);
    scanN(2); checkOutput("min60_dash", 7'b0111111, 6'b111011, 1'b1);
    scanN(3); checkOutput("sec59_d5", 7'b0010000, 6'b011111, 1'b1);
    hour = 6'd1; min = 6'd0; sec = 6'd63;
    applyStimulus(1'b1, 1'b0); checkOutput("hour01_lead0", 7'b1000000, 6'b111110, 1'b1);
    scanN(4); checkOutput("sec63_dash", 7'b0111111, 6'b101111, 1'b1);
    scanN(1);

    $display("[TB] reset mid-frame");
    hour = 6'd12; min = 6'd34; sec = 6'd56;
    scanN(3);
    @(negedge clk); rst = 1'b1; ena_scan = 1'b1; ena_blink = 1'b1;
    @(negedge clk); ena_scan = 1'b0; ena_blink = 1'b0;
    checkOutput("midframe_reset", 7'h7F, 6'h3F, 1'b1);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0); checkOutput("post_reset_d0", 7'b1111001, 6'b111110, 1'b1);
    applyStimulus(1'b1, 1'b0); checkOutput("post_reset_d1", 7'b0100100, 6'b111101, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
